// File: rtl/student_circuit_pkg.sv
// Shared mode encoding and default sizing for the student circuit family.
package student_circuit_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_ACC   = 2'd1,
        MODE_MAX   = 2'd2,
        MODE_DELAY = 2'd3
    } mode_e;

    localparam int DEFAULT_W     = 8;
    localparam int DEFAULT_DEPTH = 4;

endpackage

// File: rtl/sc_delay_line.sv
// DEPTH-stage shift register with enable and synchronous active-low clear.
module sc_delay_line #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] dly_q [DEPTH];
    logic [W-1:0] dly_d [DEPTH];

    always_comb begin
        dly_d = dly_q;
        if (en) begin
            dly_d[0] = d;
            for (int i = 1; i < DEPTH; i++) begin
                dly_d[i] = dly_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            dly_q <= dly_d;
        end
    end

    assign q = dly_q[DEPTH-1];

endmodule

// File: rtl/student_circuit_q2.sv
// Multi-mode sample processor: pass-through, wrapping accumulator with sticky
// overflow, running unsigned max, or a DEPTH-sample delay, chosen by mode.
module student_circuit_q2
    import student_circuit_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic         en,
    input  logic [1:0]   mode,
    input  logic [W-1:0] cct_input,
    output logic [W-1:0] cct_output,
    output logic         ovf
);

    mode_e        mode_q, mode_d, mode_in;
    logic [W-1:0] pass_q, pass_d;
    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] maxv_q, maxv_d;
    logic         ovf_q, ovf_d;
    logic [W:0]   sum;
    logic         entry;
    logic [W-1:0] dly_out;

    assign mode_in = mode_e'(mode);
    assign entry   = (mode_in != mode_q);
    assign sum     = {1'b0, acc_q} + {1'b0, cct_input};

    sc_delay_line #(.W(W), .DEPTH(DEPTH)) u_delay (
        .clk     (clk),
        .clear_n (clear_n),
        .en      (en),
        .d       (cct_input),
        .q       (dly_out)
    );

    // Each datapath only moves while its mode is the one being sampled;
    // a mode change restarts the newly selected datapath from the input.
    always_comb begin
        mode_d = mode_q;
        pass_d = pass_q;
        acc_d  = acc_q;
        maxv_d = maxv_q;
        ovf_d  = ovf_q;
        if (en) begin
            mode_d = mode_in;
            pass_d = cct_input;
            case (mode_in)
                MODE_ACC: begin
                    if (entry) begin
                        acc_d = cct_input;
                        ovf_d = 1'b0;
                    end else begin
                        acc_d = sum[W-1:0];
                        ovf_d = ovf_q | sum[W];
                    end
                end
                MODE_MAX: begin
                    if (entry || (cct_input > maxv_q)) begin
                        maxv_d = cct_input;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            mode_q <= MODE_PASS;
            pass_q <= '0;
            acc_q  <= '0;
            maxv_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            pass_q <= pass_d;
            acc_q  <= acc_d;
            maxv_q <= maxv_d;
            ovf_q  <= ovf_d;
        end
    end

    always_comb begin
        cct_output = pass_q;
        case (mode_q)
            MODE_PASS:  cct_output = pass_q;
            MODE_ACC:   cct_output = acc_q;
            MODE_MAX:   cct_output = maxv_q;
            MODE_DELAY: cct_output = dly_out;
            default:    cct_output = pass_q;
        endcase
    end

    assign ovf = ovf_q;

endmodule

// File: doc/student_circuit_q2.md
# student_circuit_q2

Parametrised, multi-mode successor to the single-mode student circuit. It takes a W-bit sample stream and, under a 2-bit mode select, presents one of four values: the registered input, a running modular sum with a sticky overflow flag, a running unsigned maximum, or the input delayed by DEPTH samples. It is the exam-bench device under test: the testbench drives `cct_input`, `mode` and `en` and signs `cct_output` and `ovf` each cycle.

## Interface
- `W`, default 8: sample and output width, ≥ 2.
- `DEPTH`, default 4: delay-line length in samples, ≥ 1.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `clear_n`  in  1: synchronous, active-low reset.
- `en`  in  1: sample enable; when low, all state holds.
- `mode`  in  2: mode select; encodings are defined in the package.
- `cct_input`  in  W: sample, unsigned.
- `cct_output`  out  W: selected result.
- `ovf`  out  1: sticky accumulator overflow flag.

## Operation
- State registers:
  - `mode_q` (2 bits).
  - `pass_q`, `acc`, `maxv` (W bits each).
  - `ovf`.
  - `dly[0..DEPTH-1]` (W bits each).
- `clear_n` = 0 at an edge: every register, including `mode_q`, is set to 0. This takes priority over `en`.
- `en` = 0: every register holds. A change on `mode` is not sampled.
- `en` = 1, on every edge:
  - `mode_q` ← `mode`.
  - `pass_q` ← `cct_input`.
  - `dly[0]` ← `cct_input` and `dly[i]` ← `dly[i-1]`. The delay line shifts in every mode.
- Entry into a mode: the cycle with `en` = 1 and `mode` ≠ `mode_q`.
  - Entry into MODE_ACC: `acc` ← `cct_input`, `ovf` ← 0.
  - Entry into MODE_MAX: `maxv` ← `cct_input`.
- Steady MODE_ACC (`en` = 1, `mode` = `mode_q` = ACC):
  - `acc` ← (`acc` + `cct_input`) mod 2^W.
  - `ovf` ← `ovf` | carry-out of the W-bit add.
- Steady MODE_MAX: `maxv` ← `cct_input` if `cct_input` > `maxv` (unsigned), otherwise `maxv` holds.
- `acc`, `ovf` and `maxv` hold whenever their mode is not active. Returning to a mode restarts it through entry.
- Output select, combinational from registers only:
  - `mode_q` = PASS → `cct_output` = `pass_q`.
  - `mode_q` = ACC → `cct_output` = `acc`.
  - `mode_q` = MAX → `cct_output` = `maxv`.
  - `mode_q` = DELAY → `cct_output` = `dly[DEPTH-1]`.
- `ovf` is driven directly from its register in all modes.
- No combinational path exists from any input to any output.

## Timing
- Reset values:
  - `cct_output` = 0 (`mode_q` = PASS, `pass_q` = 0).
  - `ovf` = 0.
  - All delay stages = 0.
- Latency, counting only cycles with `en` = 1:
  - PASS: one edge.
  - ACC and MAX: the sample at edge n is reflected after edge n.
  - DELAY: the output after edge n equals the sample taken at edge n−DEPTH+1. This is DEPTH samples of latency, counting the current one.
- Mode switch: the new selection is visible after the same edge that samples the new `mode`.
- Switching to DELAY immediately shows history, because the line was shifting during the other modes.
- Reset mid-operation (for example mid-accumulate with `ovf` = 1): the outputs read 0 after the first edge with `clear_n` = 0.
- The accumulator wraps modulo 2^W. `ovf` never self-clears.

## Structure
- Package `student_circuit_pkg` contains:
  - the typedef `mode_e`, 2-bit enum: MODE_PASS = 0, MODE_ACC = 1, MODE_MAX = 2, MODE_DELAY = 3;
  - the default-parameter localparams.
- Sub-module `sc_delay_line #(W, DEPTH)`:
  - ports `clk`, `clear_n`, `en`, `d`, `q`;
  - a shift register with synchronous active-low clear.
- Top level contains the mode register, entry detection, the accumulator and max datapath, and the output multiplexer.

## Test plan
All scenarios use W = 8, DEPTH = 4 and start from a clean reset.
- Reset: `clear_n` = 0 for 2 cycles with `cct_input` = 8'hAA, `mode` = 1, `en` = 1 → `cct_output` = 8'h00, `ovf` = 0 after each edge.
- PASS: `mode` = 0, inputs 8'h11, 8'h22, 8'h33 → outputs 8'h11, 8'h22, 8'h33, each one edge later.
- ACC with overflow and restart:
  - Enter ACC with 8'h80, then 8'h90, then 8'h01 → outputs 8'h80, 8'h10, 8'h11; `ovf` = 0, 1, 1.
  - Then `mode` = 2 for one cycle, then `mode` = 1 with 8'h05 → output 8'h05, `ovf` = 0.
- MAX: inputs 8'h05, 8'h3C, 8'h12, 8'hFF, 8'h00 → outputs 8'h05, 8'h3C, 8'h3C, 8'hFF, 8'hFF.
- DELAY history: in PASS, apply inputs 8'h01 to 8'h04, then switch `mode` = 3 while applying 8'h05, 8'h06 → outputs 8'h02, 8'h03.
- Enable and reset interaction:
  - In ACC with `acc` = 8'h40, drive `en` = 0 for 3 cycles while changing `mode` to 2 and `cct_input` to 8'hFF → output stays 8'h40 and `mode_q` stays ACC.
  - Then `clear_n` = 0 for one cycle → `cct_output` = 8'h00, `ovf` = 0.
